// File: rtl/muldiv_seq_unit.sv
// Sequential RV32M multiply/divide engine: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to compute MUL/MULH/MULHSU/MULHU in one cycle with a wide multiplier.
module muldiv_seq_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned HART_ID_W  = 1,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  muldiv_start,
  input  logic [2:0]            muldiv_op,
  input  logic [XLEN-1:0]       muldiv_a,
  input  logic [XLEN-1:0]       muldiv_b,
  input  logic [HART_ID_W-1:0]  muldiv_hart_id,
  input  logic [REG_ADDR_W-1:0] muldiv_rd,
  output logic                  muldiv_busy,
  output logic                  muldiv_done,
  output logic [XLEN-1:0]       muldiv_result,
  output logic [HART_ID_W-1:0]  muldiv_done_hart_id,
  output logic [REG_ADDR_W-1:0] muldiv_done_rd
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [HART_ID_W-1:0]  hart_q, hart_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       opb_q, opb_d;
  logic                  neg_res_q, neg_res_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]       result_q, result_d;

  logic              is_div, a_sgn, b_sgn, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
  logic [2*XLEN-1:0] prod_fix;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  // Operand classification at accept; MUL keeps raw operands since low bits are sign-agnostic.
  always_comb begin
    is_div   = muldiv_op[2];
    a_sgn    = muldiv_a[XLEN-1] && (muldiv_op inside {3'd1, 3'd2, 3'd4, 3'd6});
    b_sgn    = muldiv_b[XLEN-1] && (muldiv_op inside {3'd1, 3'd4, 3'd6});
    a_mag    = a_sgn ? (~muldiv_a + XLEN'(1)) : muldiv_a;
    b_mag    = b_sgn ? (~muldiv_b + XLEN'(1)) : muldiv_b;
    div_zero = is_div && (muldiv_b == '0);
    div_ovf  = (muldiv_op inside {3'd4, 3'd6}) && (muldiv_a == {1'b1, {(XLEN-1){1'b0}}})
               && (muldiv_b == '1);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    hart_d    = hart_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_sh    = acc_q[2*XLEN-1:XLEN-1];
    rem_diff  = rem_sh - {1'b0, opb_q};
    prod_fix  = neg_res_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    if (a_sgn ^ b_sgn) fast_prod = ~fast_prod + (2*XLEN)'(1);
`endif

    unique case (state_q)
      StIdle: begin
        if (muldiv_start) begin
          op_d      = muldiv_op;
          hart_d    = muldiv_hart_id;
          rd_d      = muldiv_rd;
          cnt_d     = '0;
          acc_d     = {{XLEN{1'b0}}, a_mag};
          opb_d     = b_mag;
          neg_res_d = a_sgn ^ b_sgn;
          neg_rem_d = a_sgn;
          if (div_zero) begin
            result_d = muldiv_op[1] ? muldiv_a : '1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = muldiv_op[1] ? '0 : muldiv_a;
            state_d  = StDone;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div) begin
            result_d = (muldiv_op == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
            state_d  = StDone;
`endif
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (op_q[2]) begin
          // Restoring step: shift remainder/quotient pair left, subtract divisor if it fits.
          if (!rem_diff[XLEN]) acc_d = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                 acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(XLEN - 1)) state_d = StFix;
      end
      StFix: begin
        unique case (op_q)
          3'd0:                result_d = prod_fix[XLEN-1:0];
          3'd1, 3'd2, 3'd3:    result_d = prod_fix[2*XLEN-1:XLEN];
          3'd4, 3'd5:          result_d = neg_res_q ? (~acc_q[XLEN-1:0] + XLEN'(1))
                                                    : acc_q[XLEN-1:0];
          default:             result_d = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + XLEN'(1))
                                                    : acc_q[2*XLEN-1:XLEN];
        endcase
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      hart_q    <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      hart_q    <= hart_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign muldiv_busy         = (state_q != StIdle);
  assign muldiv_done         = (state_q == StDone);
  assign muldiv_result       = result_q;
  assign muldiv_done_hart_id = hart_q;
  assign muldiv_done_rd      = rd_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for muldiv_seq_unit: results, tags, latency, busy-ignore and mid-op reset.
module tb_muldiv_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        muldiv_start = 1'b0;
  logic [2:0]  muldiv_op = '0;
  logic [31:0] muldiv_a = '0;
  logic [31:0] muldiv_b = '0;
  logic [0:0]  muldiv_hart_id = '0;
  logic [4:0]  muldiv_rd = '0;
  logic        muldiv_busy, muldiv_done;
  logic [31:0] muldiv_result;
  logic [0:0]  muldiv_done_hart_id;
  logic [4:0]  muldiv_done_rd;

  int n_total = 0;
  int n_bad   = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 34;
`endif

  muldiv_seq_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .muldiv_start        (muldiv_start),
    .muldiv_op           (muldiv_op),
    .muldiv_a            (muldiv_a),
    .muldiv_b            (muldiv_b),
    .muldiv_hart_id      (muldiv_hart_id),
    .muldiv_rd           (muldiv_rd),
    .muldiv_busy         (muldiv_busy),
    .muldiv_done         (muldiv_done),
    .muldiv_result       (muldiv_result),
    .muldiv_done_hart_id (muldiv_done_hart_id),
    .muldiv_done_rd      (muldiv_done_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op at a negedge, then count negedges until done (bounded).
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic hart, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    muldiv_op = op; muldiv_a = a; muldiv_b = b;
    muldiv_hart_id = hart; muldiv_rd = rd; muldiv_start = 1'b1;
    @(negedge clk);
    muldiv_start = 1'b0;
    lat = 1;
    while (!muldiv_done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, muldiv_result, exp_res);
    check({tag, "_hart"}, 32'(muldiv_done_hart_id), 32'(hart));
    check({tag, "_rd"}, 32'(muldiv_done_rd), 32'(rd));
    @(negedge clk);
    check({tag, "_idle"}, 32'({muldiv_busy, muldiv_done}), 32'd0);
  endtask

  initial begin
    int dones;
    int first_hart;

    #2;
    check("rst_busy", 32'(muldiv_busy), 32'd0);
    check("rst_done", 32'(muldiv_done), 32'd0);
    check("rst_result", muldiv_result, 32'd0);
    check("rst_tags", 32'({muldiv_done_hart_id, muldiv_done_rd}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("mul",    3'd0, 32'd7,          32'd6,          1'b1, 5'd4, 32'd42,         MulLat);
    run_op("div",    3'd4, 32'hFFFF_FFEC,  32'd3,          1'b0, 5'd5, 32'hFFFF_FFFA,  34);
    run_op("rem",    3'd6, 32'hFFFF_FFEC,  32'd3,          1'b1, 5'd6, 32'hFFFF_FFFE,  34);
    run_op("divu",   3'd5, 32'd20,         32'd3,          1'b0, 5'd7, 32'd6,          34);
    run_op("remu",   3'd7, 32'd20,         32'd3,          1'b0, 5'd8, 32'd2,          34);
    run_op("divu0",  3'd5, 32'd5,          32'd0,          1'b1, 5'd9, 32'hFFFF_FFFF,  1);
    run_op("remu0",  3'd7, 32'd5,          32'd0,          1'b0, 5'd0, 32'd5,          1);
    run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 5'd1, 32'h8000_0000,  1);
    run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 5'd2, 32'd0,          1);
    run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000,  1'b0, 5'd3, 32'h4000_0000,  MulLat);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 5'd31, 32'hFFFF_FFFE, MulLat);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,          1'b0, 5'd10, 32'hFFFF_FFFF, MulLat);
    run_op("mulneg", 3'd0, 32'hFFFF_FFFD,  32'd5,          1'b1, 5'd11, 32'hFFFF_FFF1, MulLat);

    // Second request while busy must be dropped.
    @(negedge clk);
    muldiv_op = 3'd5; muldiv_a = 32'd100; muldiv_b = 32'd7;
    muldiv_hart_id = 1'b0; muldiv_rd = 5'd12; muldiv_start = 1'b1;
    @(negedge clk);
    muldiv_start = 1'b0;
    repeat (2) @(negedge clk);
    muldiv_op = 3'd0; muldiv_a = 32'd3; muldiv_b = 32'd3;
    muldiv_hart_id = 1'b1; muldiv_rd = 5'd13; muldiv_start = 1'b1;
    @(negedge clk);
    muldiv_start = 1'b0;
    dones = 0;
    first_hart = -1;
    for (int i = 0; i < 80; i++) begin
      if (muldiv_done) begin
        dones++;
        if (first_hart < 0) first_hart = int'(muldiv_done_hart_id);
        check("busy_res", muldiv_result, 32'd14);
        check("busy_rd", 32'(muldiv_done_rd), 32'd12);
      end
      @(negedge clk);
    end
    check("busy_dones", 32'(dones), 32'd1);
    check("busy_hart", 32'(first_hart), 32'd0);

    // Reset mid-divide: outputs clear, no completion.
    @(negedge clk);
    muldiv_op = 3'd4; muldiv_a = 32'd1000; muldiv_b = 32'd9;
    muldiv_hart_id = 1'b1; muldiv_rd = 5'd14; muldiv_start = 1'b1;
    @(negedge clk);
    muldiv_start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy", 32'(muldiv_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(muldiv_busy), 32'd0);
    check("rstmid_result", muldiv_result, 32'd0);
    check("rstmid_tags", 32'({muldiv_done_hart_id, muldiv_done_rd}), 32'd0);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (muldiv_done) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (muldiv_done) dones++;
    end
    check("rstmid_nodone", 32'(dones), 32'd0);
    run_op("mulpost", 3'd0, 32'd7, 32'd6, 1'b1, 5'd4, 32'd42, MulLat);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
